// File: rtl/counter_stream_checker.sv
// counter_stream_checker
//   Receive-side monitor for a bundle of free-running counters, each with a
//   parity bit. Every lane must advance by exactly 1 per cycle (mod 2^WIDTH),
//   and its parity bit must equal the XOR of the lane. Reports per-lane lock,
//   sticky sequence/parity flags, a saturating error-cycle count and a capture
//   of the first error seen.
//
//   Ports:
//     clk, rst          clock, async active-high reset
//     enable            checking enable; low returns every lane to UNLOCKED
//     counter[N][W]     counter lanes under test
//     tst[N]            parity bit per lane
//     clr_errors        synchronous clear of flags, count and capture
//     locked[N]         lane is LOCKED
//     seq_err/par_err   sticky per-lane sequence / parity error
//     err_count         cycles containing any error event, saturating
//     first_err_*       valid / lane / kind (1=parity) / counter value

// Per-lane acquisition FSM and event detection.
module counter_stream_checker_lane #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] counter_i,
    input  logic             tst_i,
    output logic             locked_o,
    output logic             seq_ev_o,
    output logic             par_ev_o
);
    typedef enum logic [1:0] {UNLOCKED, ACQ, LOCKED} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] prev_q;
    logic             step_ok;

    // Width of the sum is WIDTH, so all-ones + 1 wraps to 0 as required.
    assign step_ok  = (counter_i == prev_q + WIDTH'(1));
    assign seq_ev_o = enable_i && (state_q == LOCKED) && !step_ok;
    assign par_ev_o = enable_i && (tst_i != ^counter_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= UNLOCKED;
            prev_q   <= '0;
            locked_o <= 1'b0;
        end else if (!enable_i) begin
            state_q  <= UNLOCKED;
            locked_o <= 1'b0;
        end else begin
            prev_q <= counter_i;
            case (state_q)
                UNLOCKED: begin
                    state_q  <= ACQ;
                    locked_o <= 1'b0;
                end
                ACQ: begin
                    if (step_ok) begin
                        state_q  <= LOCKED;
                        locked_o <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (!step_ok) begin
                        state_q  <= ACQ;
                        locked_o <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= UNLOCKED;
                    locked_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

module counter_stream_checker #(
    parameter int NUM_SOURCES = 3,
    parameter int WIDTH       = 32,
    parameter int ERR_CNT_W   = 8,
    localparam int SRC_W      = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                enable,
    input  logic [NUM_SOURCES-1:0][WIDTH-1:0]   counter,
    input  logic [NUM_SOURCES-1:0]              tst,
    input  logic                                clr_errors,
    output logic [NUM_SOURCES-1:0]              locked,
    output logic [NUM_SOURCES-1:0]              seq_err,
    output logic [NUM_SOURCES-1:0]              par_err,
    output logic [ERR_CNT_W-1:0]                err_count,
    output logic                                first_err_valid,
    output logic [SRC_W-1:0]                    first_err_src,
    output logic                                first_err_par,
    output logic [WIDTH-1:0]                    first_err_value
);
    logic [NUM_SOURCES-1:0] seq_ev, par_ev;

    for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_lane
        counter_stream_checker_lane #(.WIDTH(WIDTH)) u_lane (
            .clk       (clk),
            .rst       (rst),
            .enable_i  (enable),
            .counter_i (counter[g]),
            .tst_i     (tst[g]),
            .locked_o  (locked[g]),
            .seq_ev_o  (seq_ev[g]),
            .par_ev_o  (par_ev[g])
        );
    end

    logic [NUM_SOURCES-1:0] seq_err_q, seq_err_d, par_err_q, par_err_d;
    logic [ERR_CNT_W-1:0]   cnt_q, cnt_d, cnt_base;
    logic                   fv_q, fv_d, fpar_q, fpar_d;
    logic [SRC_W-1:0]       fsrc_q, fsrc_d;
    logic [WIDTH-1:0]       fval_q, fval_d;
    logic                   any_ev, hit_par;
    logic [SRC_W-1:0]       hit_src;
    logic [WIDTH-1:0]       hit_val;

    assign any_ev = |(seq_ev | par_ev);

    // Scan high to low so the lowest erroring lane is the one left standing.
    // Sequence beats parity within a lane.
    always_comb begin
        hit_src = '0;
        hit_par = 1'b0;
        hit_val = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (seq_ev[i] || par_ev[i]) begin
                hit_src = SRC_W'(i);
                hit_par = !seq_ev[i];
                hit_val = counter[i];
            end
        end
    end

    // clr_errors wipes the old state first; same-cycle events then land on top.
    always_comb begin
        seq_err_d = (clr_errors ? '0 : seq_err_q) | seq_ev;
        par_err_d = (clr_errors ? '0 : par_err_q) | par_ev;
        cnt_base  = clr_errors ? '0 : cnt_q;
        cnt_d     = (any_ev && (cnt_base != '1)) ? cnt_base + ERR_CNT_W'(1) : cnt_base;
        fv_d      = clr_errors ? 1'b0 : fv_q;
        fsrc_d    = clr_errors ? '0   : fsrc_q;
        fpar_d    = clr_errors ? 1'b0 : fpar_q;
        fval_d    = clr_errors ? '0   : fval_q;
        if (!fv_d && any_ev) begin
            fv_d   = 1'b1;
            fsrc_d = hit_src;
            fpar_d = hit_par;
            fval_d = hit_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_err_q <= '0;
            par_err_q <= '0;
            cnt_q     <= '0;
            fv_q      <= 1'b0;
            fsrc_q    <= '0;
            fpar_q    <= 1'b0;
            fval_q    <= '0;
        end else begin
            seq_err_q <= seq_err_d;
            par_err_q <= par_err_d;
            cnt_q     <= cnt_d;
            fv_q      <= fv_d;
            fsrc_q    <= fsrc_d;
            fpar_q    <= fpar_d;
            fval_q    <= fval_d;
        end
    end

    assign seq_err         = seq_err_q;
    assign par_err         = par_err_q;
    assign err_count       = cnt_q;
    assign first_err_valid = fv_q;
    assign first_err_src   = fsrc_q;
    assign first_err_par   = fpar_q;
    assign first_err_value = fval_q;
endmodule

// File: tb/tb_counter_stream_checker.sv
module tb_counter_stream_checker;
    localparam int N  = 3;
    localparam int W  = 32;
    localparam int CW = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                enable = 1'b0;
    logic                clr_errors = 1'b0;
    logic [N-1:0][W-1:0] counter = '0;
    logic [N-1:0]        tst = '0;
    logic [N-1:0]        locked, seq_err, par_err;
    logic [CW-1:0]       err_count;
    logic                first_err_valid, first_err_par;
    logic [1:0]          first_err_src;
    logic [W-1:0]        first_err_value;

    int total = 0;
    int bad   = 0;

    // Stimulus source: per-lane next value plus per-lane parity corruption.
    logic [W-1:0] base [N];
    logic [N-1:0] inj = '0;

    // Reference model, written from the lane rules: a lane is locked after an
    // edge iff it was enabled, had a previous enabled sample, and stepped by 1.
    logic [N-1:0] m_locked, m_have, m_seq, m_par;
    logic [W-1:0] m_prev [N];
    int           m_cnt, m_fsrc;
    logic         m_fv, m_fpar;
    logic [W-1:0] m_fval;

    counter_stream_checker #(.NUM_SOURCES(N), .WIDTH(W), .ERR_CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .enable(enable), .counter(counter), .tst(tst),
        .clr_errors(clr_errors), .locked(locked), .seq_err(seq_err), .par_err(par_err),
        .err_count(err_count), .first_err_valid(first_err_valid),
        .first_err_src(first_err_src), .first_err_par(first_err_par),
        .first_err_value(first_err_value)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_locked = '0; m_have = '0; m_seq = '0; m_par = '0;
        for (int i = 0; i < N; i++) m_prev[i] = '0;
        m_cnt = 0; m_fsrc = 0; m_fv = 1'b0; m_fpar = 1'b0; m_fval = '0;
    endtask

    task automatic model_update();
        logic         any;
        logic [N-1:0] nl;
        any = 1'b0;
        nl  = '0;
        if (clr_errors) begin
            m_seq = '0; m_par = '0; m_cnt = 0;
            m_fv = 1'b0; m_fsrc = 0; m_fpar = 1'b0; m_fval = '0;
        end
        for (int i = 0; i < N; i++) begin
            logic         s, p;
            logic [W-1:0] nxt;
            nxt = m_prev[i] + 32'd1;
            s = enable && m_locked[i] && (counter[i] != nxt);
            p = enable && (tst[i] != ^counter[i]);
            if (s) m_seq[i] = 1'b1;
            if (p) m_par[i] = 1'b1;
            if ((s || p) && !any && !m_fv) begin
                m_fv = 1'b1; m_fsrc = i; m_fpar = !s; m_fval = counter[i];
            end
            if (s || p) any = 1'b1;
            nl[i] = enable && m_have[i] && (counter[i] == nxt);
            if (enable) m_prev[i] = counter[i];
        end
        m_locked = nl;
        m_have   = {N{enable}};
        if (any && m_cnt < 255) m_cnt++;
    endtask

    // One clock: present base/inj, update model at the edge, settle at negedge.
    task automatic cyc();
        for (int i = 0; i < N; i++) begin
            counter[i] = base[i];
            tst[i]     = (^base[i]) ^ inj[i];
        end
        @(posedge clk);
        model_update();
        @(negedge clk);
        for (int i = 0; i < N; i++) base[i] = base[i] + 32'd1;
    endtask

    task automatic do_reset();
        rst = 1'b1; clr_errors = 1'b0; inj = '0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < N; i++) base[i] = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({locked, seq_err, par_err, err_count, first_err_valid, first_err_src,
             first_err_par, first_err_value} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got locked=%b seq=%b par=%b cnt=%0d fv=%b fsrc=%0d fpar=%b fval=%h exp all zero",
                     locked, seq_err, par_err, err_count, first_err_valid, first_err_src,
                     first_err_par, first_err_value);
        end
    endtask

    task automatic test_lock();
        do_reset();
        enable = 1'b1;
        cyc();
        total++;
        if (locked !== 3'b000) begin bad++; $display("FAIL lock_first got=%b exp=000", locked); end
        cyc();
        total++;
        if (locked !== 3'b111) begin bad++; $display("FAIL lock_second got=%b exp=111", locked); end
        for (int k = 0; k < 100; k++) begin
            cyc();
            total++;
            if ({locked, seq_err, par_err, err_count} !== {3'b111, 3'b000, 3'b000, 8'd0}) begin
                bad++;
                $display("FAIL lock_steady cyc=%0d got locked=%b seq=%b par=%b cnt=%0d exp 111/000/000/0",
                         k, locked, seq_err, par_err, err_count);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        base[1] = 32'hFFFF_FFFE;
        enable = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            total++;
            if (seq_err[1] !== 1'b0 || (k >= 1 && locked[1] !== 1'b1)) begin
                bad++;
                $display("FAIL wrap cyc=%0d got seq1=%b lock1=%b exp seq1=0 lock1=%b",
                         k, seq_err[1], locked[1], k >= 1);
            end
        end
    endtask

    task automatic test_seq_jump();
        do_reset();
        base[2] = 32'd7;
        enable = 1'b1;
        repeat (4) cyc();
        base[2] = 32'd12;
        cyc();
        total++;
        if ({seq_err, par_err, err_count} !== {3'b100, 3'b000, 8'd1}) begin
            bad++;
            $display("FAIL jump_flags got seq=%b par=%b cnt=%0d exp 100/000/1", seq_err, par_err, err_count);
        end
        total++;
        if ({first_err_valid, first_err_src, first_err_par, first_err_value} !== {1'b1, 2'd2, 1'b0, 32'd12}) begin
            bad++;
            $display("FAIL jump_capture got fv=%b src=%0d par=%b val=%0d exp 1/2/0/12",
                     first_err_valid, first_err_src, first_err_par, first_err_value);
        end
        total++;
        if (locked !== 3'b011) begin bad++; $display("FAIL jump_unlock got=%b exp=011", locked); end
        cyc();
        total++;
        if (locked !== 3'b111) begin bad++; $display("FAIL jump_relock got=%b exp=111", locked); end
    endtask

    task automatic test_par_seq_clear();
        logic [W-1:0] v0;
        do_reset();
        enable = 1'b1;
        repeat (3) cyc();
        inj[0] = 1'b1;
        base[2] = base[2] + 32'd1;
        v0 = base[0];
        cyc();
        inj = '0;
        total++;
        if ({par_err, seq_err, err_count} !== {3'b001, 3'b100, 8'd1}) begin
            bad++;
            $display("FAIL both_flags got par=%b seq=%b cnt=%0d exp 001/100/1", par_err, seq_err, err_count);
        end
        total++;
        if ({first_err_valid, first_err_src, first_err_par, first_err_value} !== {1'b1, 2'd0, 1'b1, v0}) begin
            bad++;
            $display("FAIL both_capture got fv=%b src=%0d par=%b val=%h exp 1/0/1/%h",
                     first_err_valid, first_err_src, first_err_par, first_err_value, v0);
        end
        clr_errors = 1'b1;
        cyc();
        clr_errors = 1'b0;
        total++;
        if ({seq_err, par_err, err_count, first_err_valid, first_err_src, first_err_par,
             first_err_value} !== '0) begin
            bad++;
            $display("FAIL clear got seq=%b par=%b cnt=%0d fv=%b src=%0d par=%b val=%h exp all zero",
                     seq_err, par_err, err_count, first_err_valid, first_err_src, first_err_par,
                     first_err_value);
        end
    endtask

    task automatic test_saturate();
        logic [W-1:0] v1;
        do_reset();
        enable = 1'b1;
        repeat (3) cyc();
        inj[1] = 1'b1;
        v1 = base[1];
        repeat (300) cyc();
        inj = '0;
        total++;
        if (err_count !== 8'd255) begin bad++; $display("FAIL saturate got=%0d exp=255", err_count); end
        total++;
        if ({first_err_valid, first_err_src, first_err_par, first_err_value, par_err} !==
            {1'b1, 2'd1, 1'b1, v1, 3'b010}) begin
            bad++;
            $display("FAIL sat_capture got fv=%b src=%0d par=%b val=%h pe=%b exp 1/1/1/%h/010",
                     first_err_valid, first_err_src, first_err_par, first_err_value, par_err, v1);
        end
    endtask

    task automatic test_enable_and_reset();
        do_reset();
        enable = 1'b1;
        repeat (3) cyc();
        enable = 1'b0;
        base[0] = base[0] + 32'd7;
        for (int k = 0; k < 5; k++) begin
            cyc();
            total++;
            if ({locked, seq_err, par_err, err_count} !== '0) begin
                bad++;
                $display("FAIL disabled cyc=%0d got locked=%b seq=%b par=%b cnt=%0d exp all zero",
                         k, locked, seq_err, par_err, err_count);
            end
        end
        enable = 1'b1;
        cyc();
        total++;
        if (locked !== 3'b000) begin bad++; $display("FAIL reen_first got=%b exp=000", locked); end
        cyc();
        total++;
        if ({locked, seq_err} !== {3'b111, 3'b000}) begin
            bad++;
            $display("FAIL reen_relock got locked=%b seq=%b exp 111/000", locked, seq_err);
        end
        inj[2] = 1'b1;
        cyc();
        inj = '0;
        total++;
        if (par_err !== 3'b100) begin bad++; $display("FAIL pre_rst_par got=%b exp=100", par_err); end
        // Assert reset between edges: outputs must clear without a clock.
        #2 rst = 1'b1;
        #1;
        total++;
        if ({locked, seq_err, par_err, err_count, first_err_valid, first_err_src,
             first_err_par, first_err_value} !== '0) begin
            bad++;
            $display("FAIL async_rst got locked=%b seq=%b par=%b cnt=%0d fv=%b exp all zero",
                     locked, seq_err, par_err, err_count, first_err_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cyc();
        total++;
        if ({locked, seq_err, err_count} !== '0) begin
            bad++;
            $display("FAIL post_rst got locked=%b seq=%b cnt=%0d exp zero", locked, seq_err, err_count);
        end
        cyc();
        total++;
        if (locked !== 3'b111) begin bad++; $display("FAIL post_rst_lock got=%b exp=111", locked); end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            enable     = ($urandom_range(0, 24) != 0);
            clr_errors = ($urandom_range(0, 39) == 0);
            for (int i = 0; i < N; i++) begin
                inj[i] = ($urandom_range(0, 29) == 0);
                case ($urandom_range(0, 49))
                    0: base[i] = base[i] + 32'($urandom_range(2, 9));
                    1: base[i] = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                    2: base[i] = $urandom;
                    default: ;
                endcase
            end
            cyc();
            total++;
            if ({locked, seq_err, par_err, err_count} !== {m_locked, m_seq, m_par, 8'(m_cnt)}) begin
                bad++;
                $display("FAIL rand_state cyc=%0d got lk=%b se=%b pe=%b cnt=%0d exp lk=%b se=%b pe=%b cnt=%0d",
                         k, locked, seq_err, par_err, err_count, m_locked, m_seq, m_par, m_cnt);
            end
            total++;
            if ({first_err_valid, first_err_src, first_err_par, first_err_value} !==
                {m_fv, 2'(m_fsrc), m_fpar, m_fval}) begin
                bad++;
                $display("FAIL rand_capture cyc=%0d got fv=%b src=%0d par=%b val=%h exp fv=%b src=%0d par=%b val=%h",
                         k, first_err_valid, first_err_src, first_err_par, first_err_value,
                         m_fv, m_fsrc, m_fpar, m_fval);
            end
        end
        clr_errors = 1'b0;
        inj = '0;
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < N; i++) base[i] = '0;
        test_reset();
        test_lock();
        test_wrap();
        test_seq_jump();
        test_par_seq_clear();
        test_saturate();
        test_enable_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
